// File: rtl/sha256_bench_feeder.sv
// rtl/sha256_bench_feeder.sv - feeds nonce-stamped blocks to a sha256 core for a timed benchmark window
//
// Parameters:
//   BENCHMARKSECONDS  window length in seconds (0..600)
//   CLK_HZ            clk frequency, sets the one-second tick period
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             single-cycle pulse, begins a run (ignored while busy)
//   input_buffer      64-byte template, byte 0 = input_buffer[0]; bytes 60..63 replaced by nonce
//   blk_data/valid    block to the core, transferred when blk_valid & blk_ready
//   blk_ready         core can accept a block
//   hash_done         single-cycle digest-complete pulse from the core
//   hash_digest       core digest, valid with hash_done
//   busy, bench_done  run in progress / run finished (held until next start)
//   hash_count        completed hashes in the current/last run (saturating)
//   last_digest       digest captured on the most recent counted hash_done
module sha256_bench_feeder #(
    parameter int BENCHMARKSECONDS = 10,
    parameter int CLK_HZ           = 12_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [63:0][7:0]     input_buffer,
    output logic [511:0]         blk_data,
    output logic                 blk_valid,
    input  logic                 blk_ready,
    input  logic                 hash_done,
    input  logic [255:0]         hash_digest,
    output logic                 busy,
    output logic                 bench_done,
    output logic [31:0]          hash_count,
    output logic [255:0]         last_digest
);

    generate
        if (BENCHMARKSECONDS < 0 || BENCHMARKSECONDS > 600) begin : g_bad_seconds
            $fatal(1, "sha256_bench_feeder: BENCHMARKSECONDS out of range 0..600");
        end
        if (CLK_HZ < 1) begin : g_bad_clk
            $fatal(1, "sha256_bench_feeder: CLK_HZ must be positive");
        end
    endgenerate

    localparam logic [9:0]  SEC_LIMIT = 10'(BENCHMARKSECONDS);
    localparam logic [31:0] TICK_MAX  = 32'(CLK_HZ - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t      state;
    logic [31:0] nonce;
    logic [31:0] tick;
    logic [9:0]  seconds;
    logic        closed;

    // Template bytes 60..63 are overwritten by the nonce and never reach the core.
    logic unused_tail;
    assign unused_tail = ^input_buffer[63:60];

    // Seconds saturates at the limit, so equality marks a closed window.
    assign closed = (seconds == SEC_LIMIT);

    function automatic logic [511:0] make_blk(input logic [63:0][7:0] tmpl, input logic [31:0] n);
        logic [511:0] b;
        b = '0;
        for (int k = 0; k < 60; k++) begin
            b[511 - 8*k -: 8] = tmpl[k];
        end
        b[31:0] = n;
        return b;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            nonce       <= '0;
            tick        <= '0;
            seconds     <= '0;
            blk_data    <= '0;
            blk_valid   <= 1'b0;
            busy        <= 1'b0;
            bench_done  <= 1'b0;
            hash_count  <= '0;
            last_digest <= '0;
        end else begin
            // One-second timebase runs only while a run is in progress.
            if (busy) begin
                if (tick == TICK_MAX) begin
                    tick <= '0;
                    if (!closed) begin
                        seconds <= seconds + 10'd1;
                    end
                end else begin
                    tick <= tick + 32'd1;
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        hash_count <= '0;
                        nonce      <= '0;
                        tick       <= '0;
                        seconds    <= '0;
                        if (SEC_LIMIT == 10'd0) begin
                            state      <= DONE;
                            bench_done <= 1'b1;
                        end else begin
                            state      <= ISSUE;
                            busy       <= 1'b1;
                            bench_done <= 1'b0;
                            blk_valid  <= 1'b1;
                            blk_data   <= make_blk(input_buffer, 32'd0);
                        end
                    end
                end
                ISSUE: begin
                    // A handshake in the closing cycle still goes through.
                    if (blk_ready) begin
                        nonce     <= nonce + 32'd1;
                        blk_valid <= 1'b0;
                        state     <= WAIT;
                    end else if (closed) begin
                        blk_valid  <= 1'b0;
                        busy       <= 1'b0;
                        bench_done <= 1'b1;
                        state      <= DONE;
                    end
                end
                WAIT: begin
                    if (hash_done) begin
                        if (hash_count != 32'hFFFF_FFFF) begin
                            hash_count <= hash_count + 32'd1;
                        end
                        last_digest <= hash_digest;
                        if (closed) begin
                            busy       <= 1'b0;
                            bench_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            blk_valid <= 1'b1;
                            blk_data  <= make_blk(input_buffer, nonce);
                            state     <= ISSUE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_bench_feeder.sv
// tb/tb_sha256_bench_feeder.sv - directed self-checking bench for sha256_bench_feeder
module tb_sha256_bench_feeder;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             start0 = 1'b0;
    logic [63:0][7:0] ib;
    logic             blk_ready = 1'b0;
    logic             hash_done = 1'b0;
    logic [255:0]     hash_digest = '0;

    logic [511:0] blk_data,  blk_data0;
    logic         blk_valid, blk_valid0;
    logic         busy,      busy0;
    logic         bench_done, bench_done0;
    logic [31:0]  hash_count, hash_count0;
    logic [255:0] last_digest, last_digest0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [511:0] blocks[$];
    logic [255:0] exp_last;
    int           done_idx = 0;

    always #5 clk = ~clk;

    sha256_bench_feeder #(.BENCHMARKSECONDS(2), .CLK_HZ(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .input_buffer(ib),
        .blk_data(blk_data), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .hash_done(hash_done), .hash_digest(hash_digest), .busy(busy),
        .bench_done(bench_done), .hash_count(hash_count), .last_digest(last_digest)
    );

    sha256_bench_feeder #(.BENCHMARKSECONDS(0), .CLK_HZ(10)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .input_buffer(ib),
        .blk_data(blk_data0), .blk_valid(blk_valid0), .blk_ready(blk_ready),
        .hash_done(hash_done), .hash_digest(hash_digest), .busy(busy0),
        .bench_done(bench_done0), .hash_count(hash_count0), .last_digest(last_digest0)
    );

    function automatic logic [511:0] exp_blk(input logic [31:0] n);
        logic [511:0] b;
        b = '0;
        for (int k = 0; k < 60; k++) b[511 - 8*k -: 8] = 8'(k);
        b[31:0] = n;
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Core model: accepts whenever ready, answers 5 cycles after each handshake.
    task automatic run_core(input int max_cycles, output int hs_cnt);
        int cd;
        logic hs;
        cd = 0;
        hs_cnt = 0;
        blocks.delete();
        blk_ready = 1'b1;
        for (int c = 0; c < max_cycles; c++) begin
            hs = blk_valid && blk_ready;
            if (hs) blocks.push_back(blk_data);
            step();
            hash_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    done_idx++;
                    hash_done   = 1'b1;
                    hash_digest = {8{32'hD16E_0000 | 32'(done_idx)}};
                    exp_last    = hash_digest;
                end
            end
            if (hs) begin
                hs_cnt++;
                cd = 4;
            end
            if (bench_done && cd == 0 && !hash_done) return;
        end
        n_checks++; n_fail++;
        $display("FAIL run_core_timeout: got bench_done=%0b required 1 within %0d cycles", bench_done, max_cycles);
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if (blk_valid !== 1'b0) begin n_fail++; $display("FAIL reset_blk_valid: got %b required 0", blk_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_checks++; if (bench_done !== 1'b0) begin n_fail++; $display("FAIL reset_bench_done: got %b required 0", bench_done); end
        n_checks++; if (hash_count !== 32'd0) begin n_fail++; $display("FAIL reset_hash_count: got %h required 0", hash_count); end
        n_checks++; if (blk_data !== 512'd0) begin n_fail++; $display("FAIL reset_blk_data: got %h required 0", blk_data); end
        n_checks++; if (bench_done0 !== 1'b0) begin n_fail++; $display("FAIL reset_bench_done0: got %b required 0", bench_done0); end
        step(); step();
        rst_n = 1'b1;
        step(); step(); step();
        n_checks++; if (blk_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_no_issue: got %b required 0", blk_valid); end
    endtask

    task automatic test_window_run();
        int hs;
        pulse_start();
        n_checks++; if (blk_valid !== 1'b1) begin n_fail++; $display("FAIL issue_latency: got %b required 1", blk_valid); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL run_busy: got %b required 1", busy); end
        n_checks++; if (blk_data[511:480] !== 32'h0001_0203) begin n_fail++; $display("FAIL first_blk_top: got %h required 00010203", blk_data[511:480]); end
        n_checks++; if (blk_data[63:0] !== 64'h3839_3A3B_0000_0000) begin n_fail++; $display("FAIL first_blk_tail: got %h required 38393a3b00000000", blk_data[63:0]); end
        run_core(60, hs);
        n_checks++; if (hs !== 4) begin n_fail++; $display("FAIL handshake_count: got %0d required 4", hs); end
        n_checks++; if (hash_count !== 32'(hs)) begin n_fail++; $display("FAIL hash_count: got %0d required %0d", hash_count, hs); end
        n_checks++; if (bench_done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL done_flags: got done=%b busy=%b required 1/0", bench_done, busy); end
        n_checks++; if (last_digest !== exp_last) begin n_fail++; $display("FAIL last_digest: got %h required %h", last_digest, exp_last); end
        for (int i = 0; i < blocks.size(); i++) begin
            n_checks++;
            if (blocks[i] !== exp_blk(32'(i))) begin n_fail++; $display("FAIL block_%0d: got %h required %h", i, blocks[i], exp_blk(32'(i))); end
        end
        // Stray hash_done in DONE must be ignored; no further blocks.
        hash_done = 1'b1;
        hash_digest = {8{32'hBAD0_BAD0}};
        step();
        hash_done = 1'b0;
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (blk_valid !== 1'b0) begin n_fail++; $display("FAIL no_valid_after_done: got %b required 0", blk_valid); end
            step();
        end
        n_checks++; if (hash_count !== 32'd4) begin n_fail++; $display("FAIL stray_done_count: got %0d required 4", hash_count); end
        n_checks++; if (last_digest !== exp_last) begin n_fail++; $display("FAIL stray_done_capture: got %h required %h", last_digest, exp_last); end
        n_checks++; if (bench_done !== 1'b1) begin n_fail++; $display("FAIL done_held: got %b required 1", bench_done); end
    endtask

    task automatic test_ready_stall();
        int hs;
        blk_ready = 1'b0;
        pulse_start();
        n_checks++; if (hash_count !== 32'd0 || bench_done !== 1'b0) begin n_fail++; $display("FAIL restart_clear: got count=%0d done=%b required 0/0", hash_count, bench_done); end
        for (int c = 0; c < 7; c++) begin
            n_checks++; if (blk_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid_%0d: got %b required 1", c, blk_valid); end
            n_checks++; if (blk_data !== exp_blk(32'd0)) begin n_fail++; $display("FAIL stall_data_%0d: got %h required %h", c, blk_data, exp_blk(32'd0)); end
            pulse_start(); // start while busy is ignored
        end
        run_core(60, hs);
        n_checks++; if (hs < 1 || blocks[0] !== exp_blk(32'd0)) begin n_fail++; $display("FAIL stall_first_nonce: got hs=%0d nonce=%h required nonce 0", hs, blocks[0][31:0]); end
        n_checks++; if (hash_count !== 32'(hs)) begin n_fail++; $display("FAIL stall_hash_count: got %0d required %0d", hash_count, hs); end
    endtask

    task automatic test_zero_window();
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        n_checks++; if (bench_done0 !== 1'b1 || busy0 !== 1'b0) begin n_fail++; $display("FAIL zero_done: got done=%b busy=%b required 1/0", bench_done0, busy0); end
        n_checks++; if (hash_count0 !== 32'd0) begin n_fail++; $display("FAIL zero_count: got %0d required 0", hash_count0); end
        for (int c = 0; c < 4; c++) begin
            n_checks++; if (blk_valid0 !== 1'b0) begin n_fail++; $display("FAIL zero_valid_%0d: got %b required 0", c, blk_valid0); end
            step();
        end
    endtask

    task automatic test_reset_mid_wait();
        blk_ready = 1'b1;
        pulse_start();
        step();
        n_checks++; if (blk_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL reach_wait: got valid=%b busy=%b required 0/1", blk_valid, busy); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({blk_valid, busy, bench_done} !== 3'b000) begin n_fail++; $display("FAIL async_reset_flags: got %b required 000", {blk_valid, busy, bench_done}); end
        n_checks++; if (last_digest !== 256'd0 || hash_count !== 32'd0 || blk_data !== 512'd0) begin n_fail++; $display("FAIL async_reset_data: got count=%0d digest=%h required 0", hash_count, last_digest); end
        step();
        rst_n = 1'b1;
        blk_ready = 1'b0;
        hash_done = 1'b1;
        hash_digest = {8{32'h1234_5678}};
        step();
        hash_done = 1'b0;
        n_checks++; if (hash_count !== 32'd0 || last_digest !== 256'd0) begin n_fail++; $display("FAIL post_reset_done_ignored: got count=%0d digest=%h required 0", hash_count, last_digest); end
        pulse_start();
        n_checks++; if (blk_valid !== 1'b1 || blk_data !== exp_blk(32'd0)) begin n_fail++; $display("FAIL restart_nonce0: got valid=%b nonce=%h required 1/0", blk_valid, blk_data[31:0]); end
    endtask

    initial begin
        for (int k = 0; k < 64; k++) ib[k] = 8'(k);
        exp_last = '0;
        test_reset();
        test_window_run();
        test_ready_stall();
        test_zero_window();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
